// File: rtl/des_decipher_controller.sv
// -----------------------------------------------------------------------------
// des_decipher_controller
//
// Sequencing controller for the DES decipher path. It drives the shared round
// datapath and key scheduler through one 16-round block. Round keys are used in
// reverse order, so the key scheduler rotates C/D right. The result is handed
// over with a valid/ready handshake.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   des_decipher_en  start request (level); a rising edge of the synchronised
//                    copy starts one block, honoured only while idle
//   dout_ready       downstream accepts the result
//   ip_load          load ciphertext through IP into L/R
//   rkey_load        load PC1(key) into C/D
//   rkey_sel         key scheduler uses the rotated C/D path (rounds only)
//   rkey_shift       right-rotate amount for C/D this cycle (0, 1 or 2)
//   round_en         L/R update with the round function
//   round_cnt        round index 0..15 (round 0 uses K16)
//   fp_load          capture R16L16 through FP into the output register
//   dout_valid       result available, held until dout_ready
//   decipher_process busy flag, high from LOAD through DONE
//
// All outputs are registered. They are computed from the next state, so each
// strobe lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module des_decipher_controller #(
  parameter int SYNC_STAGES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       des_decipher_en,
  input  logic       dout_ready,
  output logic       ip_load,
  output logic       rkey_load,
  output logic       rkey_sel,
  output logic [1:0] rkey_shift,
  output logic       round_en,
  output logic [3:0] round_cnt,
  output logic       fp_load,
  output logic       dout_valid,
  output logic       decipher_process
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [3:0]             cnt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;
  logic                   start_s;

  logic                   ip_load_s;
  logic                   rkey_sel_s;
  logic [1:0]             rkey_shift_s;
  logic                   fp_load_s;
  logic                   dout_valid_s;
  logic                   busy_s;

  // Right-rotate amount for a decipher round. Round 0 uses K16, which equals
  // the unrotated PC1 value, so it needs no shift.
  function automatic logic [1:0] shift_for_round(input logic [3:0] rnd);
    logic [1:0] amt;
    case (rnd)
      4'd0:              amt = 2'd0;
      4'd1, 4'd8, 4'd15: amt = 2'd1;
      default:           amt = 2'd2;
    endcase
    return amt;
  endfunction

  generate
    if (SYNC_STAGES > 1) begin : g_sync_multi
      // Multi-stage synchroniser chain plus the edge-detect register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_r   <= '0;
          sync_d_r <= 1'b0;
        end else begin
          sync_r   <= {sync_r[SYNC_STAGES-2:0], des_decipher_en};
          sync_d_r <= sync_r[SYNC_STAGES-1];
        end
      end
    end else begin : g_sync_single
      // Single-stage synchroniser plus the edge-detect register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_r   <= '0;
          sync_d_r <= 1'b0;
        end else begin
          sync_r[0] <= des_decipher_en;
          sync_d_r  <= sync_r[0];
        end
      end
    end
  endgenerate

  // A start is a single-cycle pulse. It is only acted on in IDLE, so edges
  // seen while busy are dropped rather than queued.
  assign start_s = sync_r[SYNC_STAGES-1] & ~sync_d_r;

  // Next state, next round count and the output values for the next state.
  always_comb begin
    state_s = state_r;
    cnt_s   = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_ROUND;
      end
      ST_ROUND: begin
        if (round_cnt == 4'd15) begin
          state_s = ST_FINAL;
        end else begin
          state_s = ST_ROUND;
          cnt_s   = round_cnt + 4'd1;
        end
      end
      ST_FINAL: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (dout_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    ip_load_s    = (state_s == ST_LOAD);
    rkey_sel_s   = (state_s == ST_ROUND);
    fp_load_s    = (state_s == ST_FINAL);
    dout_valid_s = (state_s == ST_DONE);
    busy_s       = (state_s != ST_IDLE);
    if (state_s == ST_ROUND) begin
      rkey_shift_s = shift_for_round(cnt_s);
    end else begin
      rkey_shift_s = 2'd0;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      round_cnt        <= 4'd0;
      ip_load          <= 1'b0;
      rkey_load        <= 1'b0;
      rkey_sel         <= 1'b0;
      rkey_shift       <= 2'd0;
      round_en         <= 1'b0;
      fp_load          <= 1'b0;
      dout_valid       <= 1'b0;
      decipher_process <= 1'b0;
    end else begin
      state_r          <= state_s;
      round_cnt        <= cnt_s;
      ip_load          <= ip_load_s;
      rkey_load        <= ip_load_s;
      rkey_sel         <= rkey_sel_s;
      rkey_shift       <= rkey_shift_s;
      round_en         <= rkey_sel_s;
      fp_load          <= fp_load_s;
      dout_valid       <= dout_valid_s;
      decipher_process <= busy_s;
    end
  end

endmodule
